vga_timing_receiver: RTL
========================

// Module: vga_timing_receiver
// PURPOSE
//  Sink-side counterpart of the VGA timing generator: samples Hsync/Vsync/RGB of a VGA stream,
//  recovers pixel coordinates, measures line length and frame height, and declares lock.
//  Sits in front of frame-capture/checker logic; emits coordinate-tagged active pixels only when locked.
// PARAMETERS
//  H_START   144  pixel samples from Hsync falling edge (count 0) to first active pixel
//  H_ACTIVE  640  active pixels per line
//  V_START   35   lines from Vsync-aligned line 0 to first active line
//  V_ACTIVE  480  active lines per frame
//  H_TOL     2    allowed +/- deviation in line length while locked (pixel samples)
// PORTS
//  Clk         in   1   system clock, all logic on rising edge
//  Rst_n       in   1   synchronous reset, active low
//  PixelEn     in   1   one-cycle strobe per pixel period; inputs sampled only when high
//  Hsync       in   1   horizontal sync, active low
//  Vsync       in   1   vertical sync, active low
//  InR/InG/InB in   8   incoming pixel colour
//  PixelValid  out  1   registered active pixel strobe
//  PosX        out  10  active column 0..H_ACTIVE-1
//  PosY        out  10  active row 0..V_ACTIVE-1
//  OutR/G/B    out  8   registered pixel colour, aligned with PixelValid
//  FrameStart  out  1   one-cycle pulse on the PosX=0,PosY=0 pixel
//  LineLen     out  11  measured pixel samples per line (locked reference)
//  FrameLines  out  11  measured lines per frame (locked reference)
//  Locked      out  1   timing stable
//  TimingError out  1   one-cycle pulse on loss of lock
// BEHAVIOUR
//  - Reset: all outputs 0, HCount=VCount=0, FSM=SEARCH, previous-sync registers=1, pending flag=0.
//  - Edge detect on PixelEn samples only: fall = prev 1 and current 0; prev updated each PixelEn.
//  - HCount (11b): 0 on the Hsync-fall sample, else +1 per PixelEn; saturates at 2047.
//  - Vsync fall sets vpend; on Hsync fall: if vpend or Vsync fall on same sample -> VCount=0,
//    vpend=0, frame boundary; else VCount+1 (saturate 2047). Line length = HCount+1 before fall.
//  - FSM: SEARCH -> MEASURE on first frame boundary.
//    MEASURE: at each Hsync fall latch line length into LineLen (last value kept); at next frame
//    boundary latch VCount+1 into FrameLines -> VERIFY.
//    VERIFY: one full frame; every line |len-LineLen|<=H_TOL and frame lines == FrameLines -> LOCKED
//    at boundary; any mismatch -> SEARCH (no TimingError pulse, Locked never rose).
//    LOCKED: Locked=1; a line outside tolerance, frame line count mismatch, or HCount/VCount
//    saturation -> TimingError pulse 1 cycle, Locked=0 same cycle, FSM=SEARCH.
//  - Active window: HCount in [H_START, H_START+H_ACTIVE-1] and VCount in [V_START, V_START+V_ACTIVE-1].
//  - Latency: 1 Clk after the sampling PixelEn cycle: PixelValid=1 (only if LOCKED), PosX=HCount-H_START,
//    PosY=VCount-V_START, Out* = In*. PixelValid low on all non-PixelEn cycles; Pos/Out hold.
//  - FrameStart asserted with PixelValid when PosX=0 and PosY=0.
//  - Lock loss mid-frame: PixelValid drops on next cycle; no partial-frame flush.
//  - Rst_n low mid-frame: full reset next edge; reacquire from SEARCH.
//  - PixelEn low for many cycles: state frozen, no timeout on Clk.
//  - Hsync fall while HCount<H_START or other edges of Vsync inside a line: only counted as specified above.
// TESTING
//  - 800x525 stream (sync 96/2, PixelEn every 2nd Clk): Locked=1 at end of 3rd frame boundary,
//    LineLen=800, FrameLines=525; first PixelValid has PosX=0,PosY=0,FrameStart=1.
//  - Locked, RGB=pixel index pattern: PixelValid count per frame = 307200, last PosX=639,PosY=479, data 1 Clk late.
//  - Locked, one line 803 samples long (H_TOL=2): TimingError pulse once, Locked=0, relock after 2 clean frames.
//  - Locked, one line 801 samples: no error, Locked stays 1.
//  - Locked, frame with 524 lines: TimingError at that frame boundary; Hsync held high: HCount saturates -> error.
//  - Rst_n low 1 cycle mid-frame: all outputs 0 next cycle, Locked rises again after MEASURE+VERIFY frames.

Source files
------------

// File: rtl/vga_timing_receiver.sv
// VGA stream receiver: recovers pixel coordinates from Hsync/Vsync, measures line and frame
// geometry, and forwards coordinate-tagged active pixels once the timing has been verified.
module vga_timing_receiver #(
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480,
    parameter int H_TOL    = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        PixelEn,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic [7:0]  InR,
    input  logic [7:0]  InG,
    input  logic [7:0]  InB,
    output logic        PixelValid,
    output logic [9:0]  PosX,
    output logic [9:0]  PosY,
    output logic [7:0]  OutR,
    output logic [7:0]  OutG,
    output logic [7:0]  OutB,
    output logic        FrameStart,
    output logic [10:0] LineLen,
    output logic [10:0] FrameLines,
    output logic        Locked,
    output logic        TimingError
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_VERIFY  = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [10:0] H_FIRST = 11'(H_START);
    localparam logic [10:0] H_LAST  = 11'(H_START + H_ACTIVE - 1);
    localparam logic [10:0] V_FIRST = 11'(V_START);
    localparam logic [10:0] V_LAST  = 11'(V_START + V_ACTIVE - 1);
    localparam logic [9:0]  H_OFF   = 10'(H_START);
    localparam logic [9:0]  V_OFF   = 10'(V_START);
    localparam logic [11:0] TOL     = 12'(H_TOL);

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + 11'd1;
    endfunction

    function automatic logic [10:0] clamp11(input logic [11:0] v);
        return v[11] ? CNT_MAX : v[10:0];
    endfunction

    function automatic logic len_ok(input logic [11:0] len, input logic [10:0] ref_len);
        logic [11:0] r12;
        logic [11:0] diff;
        r12  = {1'b0, ref_len};
        diff = (len >= r12) ? (len - r12) : (r12 - len);
        return diff <= TOL;
    endfunction

    state_t      state_r, state_n;
    logic        hsync_prev_r, vsync_prev_r, vpend_r, vpend_n;
    logic [10:0] hcount_r, hcount_n, vcount_r, vcount_n;
    logic [10:0] line_len_r, frame_lines_r;
    logic        locked_r, timing_error_r, pixel_valid_r, frame_start_r;
    logic [9:0]  pos_x_r, pos_y_r;
    logic [7:0]  out_r_r, out_g_r, out_b_r;

    logic        hfall_s, vfall_s, boundary_s;
    logic        line_bad_s, frame_bad_s, sat_s, active_s, frame_start_s;
    logic        latch_len_s, latch_lines_s, error_s;
    logic [11:0] line_len_s, frame_cnt_s;
    logic [9:0]  pos_x_s, pos_y_s;

    assign line_len_s    = {1'b0, hcount_r} + 12'd1;
    assign frame_cnt_s   = {1'b0, vcount_r} + 12'd1;
    assign line_bad_s    = hfall_s & ~len_ok(line_len_s, line_len_r);
    assign frame_bad_s   = boundary_s & (frame_cnt_s != {1'b0, frame_lines_r});
    assign sat_s         = PixelEn & ((hcount_n == CNT_MAX) | (vcount_n == CNT_MAX));
    assign active_s      = PixelEn & (hcount_n >= H_FIRST) & (hcount_n <= H_LAST)
                         & (vcount_n >= V_FIRST) & (vcount_n <= V_LAST);
    assign pos_x_s       = hcount_n[9:0] - H_OFF;
    assign pos_y_s       = vcount_n[9:0] - V_OFF;
    assign frame_start_s = active_s & (pos_x_s == 10'd0) & (pos_y_s == 10'd0);

    // Sync edge detection and horizontal/vertical position counters
    always_comb begin
        hcount_n   = hcount_r;
        vcount_n   = vcount_r;
        vpend_n    = vpend_r;
        hfall_s    = 1'b0;
        vfall_s    = 1'b0;
        boundary_s = 1'b0;
        if (PixelEn) begin
            hfall_s    = hsync_prev_r & ~Hsync;
            vfall_s    = vsync_prev_r & ~Vsync;
            boundary_s = hfall_s & (vpend_r | vfall_s);
            if (hfall_s) begin
                hcount_n = 11'd0;
                if (boundary_s) begin
                    vcount_n = 11'd0;
                    vpend_n  = 1'b0;
                end else begin
                    vcount_n = sat_inc(vcount_r);
                end
            end else begin
                hcount_n = sat_inc(hcount_r);
                vpend_n  = vpend_r | vfall_s;
            end
        end else begin
            hcount_n = hcount_r;
        end
    end

    // Lock acquisition FSM: a frame is measured, then a whole frame must match it
    always_comb begin
        state_n       = state_r;
        latch_len_s   = 1'b0;
        latch_lines_s = 1'b0;
        error_s       = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                if (boundary_s) begin
                    state_n = ST_MEASURE;
                end else begin
                    state_n = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                latch_len_s = hfall_s;
                if (boundary_s) begin
                    latch_lines_s = 1'b1;
                    state_n       = ST_VERIFY;
                end else begin
                    state_n = ST_MEASURE;
                end
            end
            ST_VERIFY: begin
                if (line_bad_s || frame_bad_s || sat_s) begin
                    state_n = ST_SEARCH;
                end else if (boundary_s) begin
                    state_n = ST_LOCKED;
                end else begin
                    state_n = ST_VERIFY;
                end
            end
            ST_LOCKED: begin
                if (line_bad_s || frame_bad_s || sat_s) begin
                    error_s = 1'b1;
                    state_n = ST_SEARCH;
                end else begin
                    state_n = ST_LOCKED;
                end
            end
            default: begin
                state_n = ST_SEARCH;
            end
        endcase
    end

    // Timing state, measurements and registered pixel outputs
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r        <= ST_SEARCH;
            hsync_prev_r   <= 1'b1;
            vsync_prev_r   <= 1'b1;
            vpend_r        <= 1'b0;
            hcount_r       <= 11'd0;
            vcount_r       <= 11'd0;
            line_len_r     <= 11'd0;
            frame_lines_r  <= 11'd0;
            locked_r       <= 1'b0;
            timing_error_r <= 1'b0;
            pixel_valid_r  <= 1'b0;
            frame_start_r  <= 1'b0;
            pos_x_r        <= 10'd0;
            pos_y_r        <= 10'd0;
            out_r_r        <= 8'd0;
            out_g_r        <= 8'd0;
            out_b_r        <= 8'd0;
        end else begin
            state_r        <= state_n;
            hcount_r       <= hcount_n;
            vcount_r       <= vcount_n;
            vpend_r        <= vpend_n;
            locked_r       <= (state_n == ST_LOCKED);
            timing_error_r <= error_s;
            pixel_valid_r  <= active_s & (state_n == ST_LOCKED);
            frame_start_r  <= frame_start_s & (state_n == ST_LOCKED);
            if (latch_len_s) begin
                line_len_r <= clamp11(line_len_s);
            end
            if (latch_lines_s) begin
                frame_lines_r <= clamp11(frame_cnt_s);
            end
            if (PixelEn) begin
                hsync_prev_r <= Hsync;
                vsync_prev_r <= Vsync;
                pos_x_r      <= pos_x_s;
                pos_y_r      <= pos_y_s;
                out_r_r      <= InR;
                out_g_r      <= InG;
                out_b_r      <= InB;
            end
        end
    end

    assign PixelValid  = pixel_valid_r;
    assign PosX        = pos_x_r;
    assign PosY        = pos_y_r;
    assign OutR        = out_r_r;
    assign OutG        = out_g_r;
    assign OutB        = out_b_r;
    assign FrameStart  = frame_start_r;
    assign LineLen     = line_len_r;
    assign FrameLines  = frame_lines_r;
    assign Locked      = locked_r;
    assign TimingError = timing_error_r;

endmodule
